// File: rtl/muldiv_if.sv
// Start/done bus between the execute stage and the RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide bit per clock.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s, rem_s, fix_res;

    // a is signed except for MULHU/DIVU/REMU; b only for MUL/MULH/DIV/REM
    always_comb begin
        a_sgn    = bus.a[WIDTH-1] &
                   (bus.op[2] ? ~bus.op[0] : ~(bus.op[1] & bus.op[0]));
        b_sgn    = bus.b[WIDTH-1] &
                   (bus.op[2] ? ~bus.op[0] : ~bus.op[1]);
        a_mag    = a_sgn ? -bus.a : bus.a;
        b_mag    = b_sgn ? -bus.b : bus.b;
        div_zero = bus.op[2] & (bus.b == '0);
        ovf      = bus.op[2] & ~bus.op[0] &
                   (bus.a == MIN) & (bus.b == ONES);
    end

    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? md_q : '0)};
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, md_q};
        div_sub = div_sh[WIDTH-1:0] - md_q;
        prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s   = neg_q ? -lo_q : lo_q;
        rem_s   = neg_q ? -hi_q : hi_q;
        if (op_q[2])
            fix_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            fix_res = prod_s[WIDTH-1:0];
        else
            fix_res = prod_s[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        md_d    = md_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d  = bus.op;
                    // remainder follows the dividend; everything else sign(a)^sign(b)
                    neg_d = (bus.op[2] & bus.op[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    if (div_zero) begin
                        res_d   = bus.op[1] ? bus.a : ONES;
                        state_d = S_DONE;
                    end else if (ovf) begin
                        res_d   = bus.op[1] ? '0 : bus.a;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH);
                        hi_d    = '0;
                        lo_d    = bus.op[2] ? a_mag : b_mag;
                        md_d    = bus.op[2] ? b_mag : a_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = fix_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            md_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            md_q    <= md_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) i32 ();
    muldiv_if #(.WIDTH(8))  i8 ();

    muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));
    muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue32(input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y);
        @(negedge clk);
        i32.start = 1'b1; i32.op = o; i32.a = x; i32.b = y;
        @(negedge clk);
        i32.start = 1'b0; i32.a = ~x; i32.b = ~y; i32.op = ~o;
    endtask

    // lat = edges after the accepting edge before done is seen
    task automatic wait32(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!i32.done && lat < 100) begin
            if (i32.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op32(input string tag, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int exp_lat);
        int lat, bc;
        issue32(o, x, y);
        wait32(lat, bc);
        check({tag, "_res"}, i32.result, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic op8(input string tag, input logic [2:0] o,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        i8.start = 1'b1; i8.op = o; i8.a = x; i8.b = y;
        @(negedge clk);
        i8.start = 1'b0; i8.a = ~x; i8.b = ~y;
        lat = 0;
        while (!i8.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_res"}, {24'd0, i8.result}, {24'd0, exp});
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int lat, bc, dn;
        i32.start = 0; i32.flush = 0; i32.op = 0; i32.a = 0; i32.b = 0;
        i8.start = 0;  i8.flush = 0;  i8.op = 0;  i8.a = 0;  i8.b = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, i32.busy}, 32'd0);
        check("rst_done", {31'd0, i32.done}, 32'd0);
        check("rst_res", i32.result, 32'd0);
        rst_n = 1'b1;

        issue32(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait32(lat, bc);
        check("mul_res", i32.result, 32'hFFFF_FFEB);
        check("mul_lat", 32'(lat), 32'd33);
        check("mul_busy", 32'(bc), 32'd33);
        check("mul_busy_done", {31'd0, i32.busy}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, i32.done}, 32'd0);

        op32("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        op32("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        op32("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        op32("div_n", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        op32("rem_n", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        op32("rem_p", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        op32("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        op32("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        op32("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        op32("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
        op32("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        op32("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        op32("remu_pre", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        issue32(3'b101, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        i32.flush = 1'b1;
        @(negedge clk);
        i32.flush = 1'b0;
        check("flush_busy", {31'd0, i32.busy}, 32'd0);
        check("flush_res", i32.result, 32'd2);
        dn = 0;
        repeat (40) begin
            if (i32.done) dn++;
            @(negedge clk);
        end
        check("flush_nodone", 32'(dn), 32'd0);

        @(negedge clk);
        i32.start = 1'b1; i32.flush = 1'b1;
        i32.op = 3'b100; i32.a = 32'd5; i32.b = 32'd0;
        @(negedge clk);
        i32.start = 1'b0; i32.flush = 1'b0;
        check("fs_done", {31'd0, i32.done}, 32'd0);
        check("fs_busy", {31'd0, i32.busy}, 32'd0);
        check("fs_res", i32.result, 32'd2);

        issue32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        i32.start = 1'b1; i32.op = 3'b111; i32.a = 32'd5; i32.b = 32'd0;
        @(negedge clk);
        i32.start = 1'b0;
        wait32(lat, bc);
        check("sb_res", i32.result, 32'hFFFF_FFFE);
        check("sb_lat", 32'(lat), 32'd28);
        @(negedge clk);
        dn = 0;
        repeat (40) begin
            if (i32.done) dn++;
            @(negedge clk);
        end
        check("sb_nodone", 32'(dn), 32'd0);

        issue32(3'b100, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, i32.busy}, 32'd0);
        check("arst_res", i32.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8("mulhu8", 3'b011, 8'hFF, 8'hFF, 8'hFE, 9);
        op8("div8_ovf", 3'b100, 8'h80, 8'hFF, 8'h80, 0);
        op8("div8", 3'b100, 8'hF9, 8'h02, 8'hFD, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
